// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between an instruction-fetch and a data requester.
// Data wins by default; fetch is guaranteed a slot after a bounded run of data grants.
module mem_port_arbiter #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned MAX_D_STREAK = 4,
    parameter int unsigned TIMEOUT      = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [XLEN-1:0]   i_addr,
    output logic              i_ack,
    output logic [XLEN-1:0]   i_rdata,
    output logic              i_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [XLEN-1:0]   d_addr,
    input  logic [XLEN-1:0]   d_wdata,
    input  logic [XLEN/8-1:0] d_wstrb,
    output logic              d_ack,
    output logic [XLEN-1:0]   d_rdata,
    output logic              d_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_wstrb,
    input  logic              mem_ack,
    input  logic [XLEN-1:0]   mem_rdata
);

    localparam int unsigned BW = XLEN / 8;
    localparam int unsigned SW = $clog2(MAX_D_STREAK + 1);
    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          grant_i;
    logic          grant_d;
    logic          expire;
    logic [SW-1:0] streak;
    logic [TW-1:0] tcnt;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state, grant selection and timeout detection
    always_comb begin
        state_nxt = state;
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        expire    = 1'b0;
        case (state)
            IDLE: begin
                if (i_req && (!d_req || streak == SW'(MAX_D_STREAK))) begin
                    grant_i   = 1'b1;
                    state_nxt = BUSY_I;
                end else if (d_req) begin
                    grant_d   = 1'b1;
                    state_nxt = BUSY_D;
                end
            end
            BUSY_I, BUSY_D: begin
                // An ack landing on the last allowed cycle wins over the timeout
                expire = !mem_ack && (tcnt == TW'(TIMEOUT - 1));
                if (mem_ack || expire) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Owner-side completion signals, combinational from state and mem_ack
    always_comb begin
        i_ack   = 1'b0;
        i_err   = 1'b0;
        i_rdata = '0;
        d_ack   = 1'b0;
        d_err   = 1'b0;
        d_rdata = '0;
        case (state)
            BUSY_I: begin
                i_ack = mem_ack;
                i_err = expire;
                if (mem_ack) i_rdata = mem_rdata;
            end
            BUSY_D: begin
                d_ack = mem_ack;
                d_err = expire;
                if (mem_ack) d_rdata = mem_rdata;
            end
            default: ;
        endcase
    end

    // Memory-side request registers, streak and timeout counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
            streak    <= '0;
            tcnt      <= '0;
        end else if (grant_i) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= i_addr;
            mem_wdata <= '0;
            mem_wstrb <= BW'(0);
            streak    <= '0;
            tcnt      <= '0;
        end else if (grant_d) begin
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_wstrb <= d_wstrb;
            tcnt      <= '0;
            if (!i_req)                             streak <= '0;
            else if (streak != SW'(MAX_D_STREAK))   streak <= streak + SW'(1);
        end else if (state != IDLE) begin
            if (mem_ack || expire) mem_req <= 1'b0;
            else                   tcnt    <= tcnt + TW'(1);
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width.
REQ-002 SHALL have parameter MAX_D_STREAK, default 4, max consecutive data grants while fetch waits.
REQ-003 SHALL have parameter TIMEOUT, default 64, cycles without mem_ack before abort.
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 i_req  in  1  instruction-fetch request, held until i_ack or i_err.
REQ-007 i_addr  in  XLEN  fetch address, stable while i_req high.
REQ-008 i_ack  out  1  fetch complete; one-cycle pulse.
REQ-009 i_rdata  out  XLEN  fetch data, valid only when i_ack=1.
REQ-010 d_req  in  1  load/store request, held until d_ack or d_err.
REQ-011 d_we  in  1  1=store, 0=load.
REQ-012 d_addr  in  XLEN  data address.
REQ-013 d_wdata  in  XLEN  store data.
REQ-014 d_wstrb  in  XLEN/8  store byte enables.
REQ-015 d_ack  out  1  data access complete; one-cycle pulse.
REQ-016 d_rdata  out  XLEN  load data, valid only when d_ack=1.
REQ-017 i_err / d_err  out  1 each  timeout abort; one-cycle pulse to owner.
REQ-018 mem_req  out  1  memory request, held until mem_ack or timeout.
REQ-019 mem_we, mem_addr, mem_wdata, mem_wstrb  out  1/XLEN/XLEN/XLEN/8  registered copy of granted request (fetch: we=0, wstrb=0, wdata=0).
REQ-020 mem_ack  in  1  memory completion, one cycle; mem_rdata valid same cycle.
REQ-021 mem_rdata  in  XLEN  memory read data.

Function
REQ-022 SHALL implement FSM states IDLE, BUSY_I, BUSY_D.
REQ-023 IDLE: if any request, SHALL select owner at the edge, latch its fields into mem_* registers, assert mem_req from next cycle, enter BUSY_I/BUSY_D.
REQ-024 Priority: d_req over i_req, except when streak counter = MAX_D_STREAK and i_req=1, then i_req SHALL win.
REQ-025 Streak counter SHALL increment on each D grant made while i_req=1, clear on any I grant or when i_req=0 at grant, saturate at MAX_D_STREAK.
REQ-026 BUSY_x: mem_* outputs SHALL remain constant; requester input changes SHALL be ignored.
REQ-027 BUSY_x with mem_ack=1: x_ack SHALL be 1 that same cycle (combinational from mem_ack and state), x_rdata = mem_rdata; next state IDLE, mem_req 0.
REQ-028 Non-owner ack/err SHALL remain 0; i_rdata/d_rdata SHALL be 0 when not acked.
REQ-029 Minimum turnaround: one IDLE cycle between consecutive accesses; request-to-mem_req latency exactly 1 cycle from IDLE.
REQ-030 Timeout counter SHALL clear on entry to BUSY_x, increment each BUSY cycle without mem_ack; on reaching TIMEOUT-1 without mem_ack, x_err SHALL pulse that cycle, mem_req drop next cycle, state IDLE.
REQ-031 mem_ack in the same cycle the counter reaches TIMEOUT-1 SHALL count as success (ack, no err).
REQ-032 mem_ack while IDLE SHALL be ignored.
REQ-033 Simultaneous i_req and d_req in IDLE, streak below limit: D granted, I waits without loss.

Reset
REQ-034 reset=0 SHALL immediately force IDLE, mem_req=0, all mem_* registers 0, ack/err 0, streak and timeout counters 0, regardless of clock.
REQ-035 Reset mid-access SHALL abandon the access with no ack or err; first grant SHALL follow the first edge after reset deasserts with a request present.

Verification
REQ-036 Single fetch: i_req, i_addr=0x100, mem_ack 3 cycles after mem_req with rdata=0x00500093 -> mem_addr=0x100, mem_we=0, i_ack pulse, i_rdata=0x00500093.
REQ-037 Store: d_req, d_we=1, d_addr=0x2000, d_wdata=0xDEADBEEF, d_wstrb=0xF -> mem_* match, d_ack on mem_ack, i_ack stays 0.
REQ-038 Contention: i_req and d_req held, mem_ack 1 cycle after each mem_req -> grant order D,D,D,D,I,D,... (MAX_D_STREAK=4).
REQ-039 Timeout: d_req, mem_ack never -> d_err pulse 64 cycles after mem_req rise, mem_req low next cycle, state IDLE; mem_ack exactly at cycle 64 -> d_ack, no d_err.
REQ-040 Reset mid-access: reset=0 in BUSY_D between edges -> mem_req 0 immediately, no d_ack; after release with i_req=1 -> fetch granted.
